// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank/show slots per digit, double-buffered
// display value swapped at frame boundaries, optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    input  logic                      lz_en,
    output logic [3:0]                num,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done
);

    localparam int CW = $clog2((DIV > BLANK_CYCLES ? DIV : BLANK_CYCLES) + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx, idx_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   active, active_nxt;
    logic [4*NUM_DIGITS-1:0]   pending, pending_nxt;
    logic                      pend_valid, pend_valid_nxt;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     supp;
    logic [3:0]                nib;
    logic [3:0]                num_nxt;
    logic [NUM_DIGITS-1:0]     sel_nxt;
    logic                      done_nxt;

    // A digit is suppressed when it and every more significant digit is exactly zero;
    // an F nibble breaks the run, and digit 0 always stays visible.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] val);
        logic [NUM_DIGITS-1:0] mask;
        logic                  zero_run;
        mask     = {NUM_DIGITS{1'b0}};
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (val[4*i +: 4] == 4'h0);
            mask[i]  = zero_run;
        end
        return mask;
    endfunction

    // Next-state, buffer and output decode; outputs are computed for the next state
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt + CW'(1);
        wrap           = 1'b0;
        case (state)
            BLANK: begin
                if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = {CW{1'b0}};
                end else begin
                    state_nxt = BLANK;
                end
            end
            SHOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = {CW{1'b0}};
                    wrap      = (idx == IDX_LAST);
                    idx_nxt   = wrap ? {IW{1'b0}} : idx + IW'(1);
                    state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                end else begin
                    state_nxt = SHOW;
                end
            end
            default: begin
                state_nxt = BLANK;
                idx_nxt   = {IW{1'b0}};
                cnt_nxt   = {CW{1'b0}};
            end
        endcase

        // A load coinciding with the swap lands in pending for the following frame.
        active_nxt     = (wrap && pend_valid) ? pending : active;
        pending_nxt    = load ? digits_in : pending;
        if (load) begin
            pend_valid_nxt = 1'b1;
        end else if (wrap) begin
            pend_valid_nxt = 1'b0;
        end else begin
            pend_valid_nxt = pend_valid;
        end

        supp = lz_en ? lz_mask(active_nxt) : {NUM_DIGITS{1'b0}};
        nib  = active_nxt[{idx_nxt, 2'b00} +: 4];
        if (state_nxt == SHOW) begin
            sel_nxt  = SEL_ONE << idx_nxt;
            num_nxt  = supp[idx_nxt] ? 4'hF : nib;
            done_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == DIV_LAST);
        end else begin
            sel_nxt  = {NUM_DIGITS{1'b0}};
            num_nxt  = 4'hF;
            done_nxt = 1'b0;
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= {IW{1'b0}};
            cnt        <= {CW{1'b0}};
            active     <= {(4*NUM_DIGITS){1'b0}};
            pending    <= {(4*NUM_DIGITS){1'b0}};
            pend_valid <= 1'b0;
            num        <= 4'hF;
            dig_sel    <= {NUM_DIGITS{1'b0}};
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
            num        <= num_nxt;
            dig_sel    <= sel_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-cycle expected outputs queued from
// hand-written frame contents, popped and compared by negedge monitors.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  num, num_nb;
    logic [3:0]  dig_sel, sel_nb;
    logic        frame_done, fd_nb;

    seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .lz_en(lz_en),
        .num(num), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .BLANK_CYCLES(0)) u_dut_nb (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .lz_en(lz_en),
        .num(num_nb), .dig_sel(sel_nb), .frame_done(fd_nb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] num;
        logic       fd;
    } rec_t;

    rec_t q[$];
    rec_t q_nb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   mon_nb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main-DUT monitor: one expected record per cycle while enabled.
    always @(negedge clk) begin
        rec_t e;
        if (mon_en && q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("scan_main t=%0t {sel,num,fd}", $time),
                  32'({dig_sel, num, frame_done}), 32'(e));
        end
    end

    // Zero-blank DUT monitor.
    always @(negedge clk) begin
        rec_t e;
        if (mon_nb_en && q_nb.size() > 0) begin
            e = q_nb.pop_front();
            check($sformatf("scan_noblank t=%0t {sel,num,fd}", $time),
                  32'({sel_nb, num_nb, fd_nb}), 32'(e));
        end
    end

    // shown: nibble s is the code expected on num during slot s (F where blanked).
    task automatic push_frame(input logic [15:0] shown, input int ncyc);
        int   k;
        rec_t r;
        k = 0;
        for (int s = 0; s < 4; s++) begin
            r.sel = 4'b0000; r.num = 4'hF; r.fd = 1'b0;
            if (k < ncyc) q.push_back(r);
            k++;
            for (int j = 0; j < 4; j++) begin
                r.sel = 4'b0001 << s;
                r.num = shown[4*s +: 4];
                r.fd  = (s == 3 && j == 3);
                if (k < ncyc) q.push_back(r);
                k++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic ld(input logic [15:0] v);
        digits_in = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rec_t r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_main", 32'({dig_sel, num, frame_done}), 32'({4'b0000, 4'hF, 1'b0}));
        check("reset_state_noblank", 32'({sel_nb, num_nb, fd_nb}), 32'({4'b0000, 4'hF, 1'b0}));

        push_frame(16'h0000, 20);
        push_frame(16'h1234, 20);
        push_frame(16'hFF50, 20);
        push_frame(16'hFFF0, 20);
        push_frame(16'h2222, 20);
        push_frame(16'h3333, 20);
        push_frame(16'hF0A0, 20);
        push_frame(16'h0007, 20);
        push_frame(16'h0007, 12);

        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;

        goto(8);   ld(16'h1234);
        goto(25);  lz_en = 1'b1; ld(16'h0050);
        goto(45);  ld(16'h0000);
        goto(62);  ld(16'h1111);
        goto(70);  ld(16'h2222);
        goto(79);  ld(16'h3333);
        goto(105); ld(16'hF0A0);
        goto(125); ld(16'h0007);
        goto(139); lz_en = 1'b0;
        goto(165); ld(16'h9999);
        goto(172);
        mon_en = 1'b0;
        check("queue_drained_before_reset", 32'(q.size()), 32'd0);

        // Mid-slot reset of idx2: outputs must clear without a clock edge.
        rst = 1'b1;
        #1;
        check("async_reset_sel", 32'(dig_sel), 32'h0);
        check("async_reset_num", 32'(num), 32'hF);
        check("async_reset_fd", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);

        q.delete();
        push_frame(16'h0000, 20);
        push_frame(16'h0000, 20);
        r.sel = 4'b0000; r.num = 4'hF; r.fd = 1'b0;
        q_nb.push_back(r);
        for (int c = 1; c <= 32; c++) begin
            r.sel = 4'b0001 << (((c - 1) / 4) % 4);
            r.num = 4'h0;
            r.fd  = (c == 16 || c == 32);
            q_nb.push_back(r);
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;
        mon_nb_en = 1'b1;
        while ((q.size() > 0 || q_nb.size() > 0) && cyc < 200) step();
        mon_en = 1'b0;
        mon_nb_en = 1'b0;
        check("drain_main", 32'(q.size()), 32'd0);
        check("drain_noblank", 32'(q_nb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
